// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator that maps note-on/off events onto NUM_VOICES voices.
// Optional build macro VOICE_STEAL_EN enables stealing the oldest voice when all are busy.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    evt_valid,
    output logic                    evt_ready,
    input  logic                    evt_note_on,
    input  logic [6:0]              evt_note,
    input  logic [6:0]              evt_velocity,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vol,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [NUM_VOICES-1:0]   voice_restart,
    output logic [7:0]              drop_count
);

    // state  | meaning
    // IDLE   | ready for an event
    // SCAN   | examine one voice per cycle, index 0..NUM_VOICES-1
    // COMMIT | apply the allocation decision
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

    state_t                  state_q, state_d;
    logic [VIDX_W-1:0]       scan_idx_q, scan_idx_d;
    logic                    ev_on_q, ev_on_d;
    logic [6:0]              ev_note_q, ev_note_d;
    logic [6:0]              ev_vel_q, ev_vel_d;
    logic                    match_vld_q, match_vld_d;
    logic [VIDX_W-1:0]       match_idx_q, match_idx_d;
    logic                    free_vld_q, free_vld_d;
    logic [VIDX_W-1:0]       free_idx_q, free_idx_d;
    logic                    old_vld_q, old_vld_d;
    logic [VIDX_W-1:0]       old_idx_q, old_idx_d;
    logic [VIDX_W-1:0]       old_age_q, old_age_d;
    logic [6:0]              note_q [NUM_VOICES];
    logic [6:0]              note_d [NUM_VOICES];
    logic [6:0]              vol_q  [NUM_VOICES];
    logic [6:0]              vol_d  [NUM_VOICES];
    logic [VIDX_W-1:0]       age_q  [NUM_VOICES];
    logic [VIDX_W-1:0]       age_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   active_q, active_d;
    logic [NUM_VOICES-1:0]   restart_q, restart_d;
    logic [7:0]              drop_q, drop_d;

    logic                    tgt_vld;
    logic                    tgt_was_free;
    logic [VIDX_W-1:0]       tgt_idx;
    logic [VIDX_W-1:0]       prev_age;

    always_comb begin
        state_d      = state_q;
        scan_idx_d   = scan_idx_q;
        ev_on_d      = ev_on_q;
        ev_note_d    = ev_note_q;
        ev_vel_d     = ev_vel_q;
        match_vld_d  = match_vld_q;
        match_idx_d  = match_idx_q;
        free_vld_d   = free_vld_q;
        free_idx_d   = free_idx_q;
        old_vld_d    = old_vld_q;
        old_idx_d    = old_idx_q;
        old_age_d    = old_age_q;
        note_d       = note_q;
        vol_d        = vol_q;
        age_d        = age_q;
        active_d     = active_q;
        restart_d    = '0;
        drop_d       = drop_q;
        tgt_vld      = 1'b0;
        tgt_was_free = 1'b0;
        tgt_idx      = '0;
        prev_age     = '0;

        case (state_q)
            IDLE: begin
                if (evt_valid) begin
                    // velocity 0 note-on is a note-off
                    ev_on_d     = evt_note_on && (evt_velocity != 7'd0);
                    ev_note_d   = evt_note;
                    ev_vel_d    = evt_velocity;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    old_age_d   = '0;
                    scan_idx_d  = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (active_q[scan_idx_q]) begin
                    if (!match_vld_q && note_q[scan_idx_q] == ev_note_q) begin
                        match_vld_d = 1'b1;
                        match_idx_d = scan_idx_q;
                    end
                    if (!old_vld_q || age_q[scan_idx_q] > old_age_q) begin
                        old_vld_d = 1'b1;
                        old_idx_d = scan_idx_q;
                        old_age_d = age_q[scan_idx_q];
                    end
                end else if (!free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (ev_on_q) begin
                    if (match_vld_q) begin
                        tgt_vld  = 1'b1;
                        tgt_idx  = match_idx_q;
                        prev_age = age_q[match_idx_q];
                    end else if (free_vld_q) begin
                        tgt_vld      = 1'b1;
                        tgt_was_free = 1'b1;
                        tgt_idx      = free_idx_q;
                    end else begin
`ifdef VOICE_STEAL_EN
                        tgt_vld  = old_vld_q;
                        tgt_idx  = old_idx_q;
                        prev_age = old_age_q;
`else
                        if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
`endif
                    end
                    if (tgt_vld) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (VIDX_W'(i) != tgt_idx && active_q[i] &&
                                (tgt_was_free || age_q[i] < prev_age) &&
                                age_q[i] != LAST_IDX) begin
                                age_d[i] = age_q[i] + 1'b1;
                            end
                        end
                        note_d[tgt_idx]    = ev_note_q;
                        vol_d[tgt_idx]     = ev_vel_q;
                        age_d[tgt_idx]     = '0;
                        active_d[tgt_idx]  = 1'b1;
                        restart_d[tgt_idx] = 1'b1;
                    end
                end else if (match_vld_q) begin
                    active_d[match_idx_q] = 1'b0;
                    vol_d[match_idx_q]    = 7'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            scan_idx_q  <= '0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= 7'd0;
            ev_vel_q    <= 7'd0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= 7'd60;
                vol_q[i]  <= 7'd0;
                age_q[i]  <= '0;
            end
            active_q    <= '0;
            restart_q   <= '0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            ev_vel_q    <= ev_vel_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            note_q      <= note_d;
            vol_q       <= vol_d;
            age_q       <= age_d;
            active_q    <= active_d;
            restart_q   <= restart_d;
            drop_q      <= drop_d;
        end
    end

    // ready is forced low while reset is held so nothing is accepted then
    assign evt_ready     = (state_q == IDLE) && !reset;
    assign voice_active  = active_q;
    assign voice_restart = restart_q;
    assign drop_count    = drop_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7] = note_q[g];
        assign voice_vol[7*g +: 7]  = vol_q[g];
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomized bench for midi_voice_allocator against a rule-level voice model.
// Follows the VOICE_STEAL_EN build setting of the design.
module tb_midi_voice_allocator;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           evt_valid;
    logic           evt_ready;
    logic           evt_note_on;
    logic [6:0]     evt_note;
    logic [6:0]     evt_velocity;
    logic [7*N-1:0] voice_note;
    logic [7*N-1:0] voice_vol;
    logic [N-1:0]   voice_active;
    logic [N-1:0]   voice_restart;
    logic [7:0]     drop_count;

    always #10 clk = ~clk;

    midi_voice_allocator #(.NUM_VOICES(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_note_on   (evt_note_on),
        .evt_note      (evt_note),
        .evt_velocity  (evt_velocity),
        .voice_note    (voice_note),
        .voice_vol     (voice_vol),
        .voice_active  (voice_active),
        .voice_restart (voice_restart),
        .drop_count    (drop_count)
    );

    int   m_note [N];
    int   m_vol  [N];
    int   m_age  [N];
    bit   m_act  [N];
    int   m_drop;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_note[i] = 60; m_vol[i] = 0; m_age[i] = 0; m_act[i] = 0;
        end
        m_drop = 0;
    endtask

    // returns the restart pattern the event should produce
    function automatic logic [N-1:0] model_apply(bit on, int note, int vel);
        int match = -1, free = -1, oldest = -1, tgt = -1, prev = 0;
        bit was_free = 0;
        logic [N-1:0] rs = '0;
        if (vel == 0) on = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] && m_note[i] == note && match < 0) match = i;
            if (!m_act[i] && free < 0) free = i;
            if (m_act[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
        end
        if (on) begin
            if (match >= 0) begin tgt = match; prev = m_age[match]; end
            else if (free >= 0) begin tgt = free; was_free = 1; end
            else begin
`ifdef VOICE_STEAL_EN
                tgt = oldest; prev = m_age[oldest];
`else
                if (m_drop < 255) m_drop++;
`endif
            end
            if (tgt >= 0) begin
                for (int i = 0; i < N; i++)
                    if (i != tgt && m_act[i] && (was_free || m_age[i] < prev) && m_age[i] < N-1)
                        m_age[i]++;
                m_note[tgt] = note; m_vol[tgt] = vel; m_age[tgt] = 0; m_act[tgt] = 1;
                rs[tgt] = 1'b1;
            end
        end else if (match >= 0) begin
            m_act[match] = 0; m_vol[match] = 0;
        end
        return rs;
    endfunction

    task automatic check_outputs(input string tag, input logic [N-1:0] exp_rs);
        logic [7*N-1:0] en, ev;
        logic [N-1:0]   ea;
        for (int i = 0; i < N; i++) begin
            en[7*i +: 7] = 7'(m_note[i]);
            ev[7*i +: 7] = 7'(m_vol[i]);
            ea[i]        = m_act[i];
        end
        chk({tag, "_note"}, 64'(voice_note), 64'(en));
        chk({tag, "_vol"}, 64'(voice_vol), 64'(ev));
        chk({tag, "_active"}, 64'(voice_active), 64'(ea));
        chk({tag, "_restart"}, 64'(voice_restart), 64'(exp_rs));
        chk({tag, "_drop"}, 64'(drop_count), 64'(m_drop));
    endtask

    // called and returns at a negedge with the DUT idle
    task automatic send(input bit on, input int note, input int vel);
        logic [N-1:0] rs;
        chk("ready_idle", 64'(evt_ready), 64'd1);
        evt_valid    = 1'b1;
        evt_note_on  = on;
        evt_note     = 7'(note);
        evt_velocity = 7'(vel);
        @(posedge clk);
        @(negedge clk);
        evt_valid = 1'b0;
        for (int k = 0; k <= N; k++) begin
            chk("busy_ready", 64'(evt_ready), 64'd0);
            check_outputs("busy", '0);
            evt_valid    = 1'($urandom_range(0, 1));
            evt_note_on  = 1'($urandom_range(0, 1));
            evt_note     = 7'($urandom_range(0, 127));
            evt_velocity = 7'($urandom_range(0, 127));
            @(posedge clk);
            @(negedge clk);
        end
        evt_valid = 1'b0;
        rs = model_apply(on, note, vel);
        chk("commit_ready", 64'(evt_ready), 64'd1);
        check_outputs("commit", rs);
        @(posedge clk);
        @(negedge clk);
        chk("pulse_end", 64'(voice_restart), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        evt_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_ready", 64'(evt_ready), 64'd0);
        check_outputs("rst", '0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_ready", 64'(evt_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; evt_valid = 1'b0; evt_note_on = 1'b0;
        evt_note = 7'd0; evt_velocity = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        send(1, 69, 100);
        do_reset();
        send(1, 60, 90); send(1, 62, 91); send(1, 64, 92); send(1, 65, 93);
        send(1, 67, 94);
        send(1, 62, 50);
        send(0, 64, 10);
        send(1, 64, 0);
        send(0, 99, 10);

        do_reset();
        send(1, 70, 1); send(1, 71, 2); send(1, 72, 3); send(1, 73, 4);
        send(1, 80, 5); send(1, 81, 6); send(1, 82, 7);

        for (int t = 0; t < 60; t++) begin
            int r = $urandom_range(0, 2);
            int v = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
            send(r != 0, $urandom_range(60, 67), v);
        end

        // reset in the middle of a scan discards the event
        evt_valid = 1'b1; evt_note_on = 1'b1; evt_note = 7'd61; evt_velocity = 7'd33;
        @(posedge clk);
        @(negedge clk);
        evt_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        send(1, 61, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
Polyphony controller that sits between the MIDI event decoder and a bank of NUM_VOICES square-wave voice generators.
- Accepts note-on/note-off events over a valid/ready handshake.
- Assigns each note to a free voice, retriggers a voice already playing the same note, or steals the oldest voice.
- Drives each voice's note number, volume, active flag and a one-cycle restart pulse.

Parameters:
NUM_VOICES, 4, number of voice generators managed (2..16)
VIDX_W, $clog2(NUM_VOICES), width of voice index and age counters

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
evt_valid  in  1  event present
evt_ready  out  1  allocator can accept an event
evt_note_on  in  1  1 = note-on, 0 = note-off
evt_note  in  7  MIDI note number
evt_velocity  in  7  MIDI velocity
voice_note  out  7*NUM_VOICES  note per voice; voice i at [7i+6:7i]
voice_vol  out  7*NUM_VOICES  volume per voice, same packing
voice_active  out  NUM_VOICES  voice sounding
voice_restart  out  NUM_VOICES  one-cycle pulse: voice must reload its period counter
drop_count  out  8  count of note-ons discarded (only nonzero when stealing is disabled)

Behaviour:
- Reset:
  - evt_ready=0 during reset, 1 in the first cycle after reset deasserts.
  - voice_note=all 60, voice_vol=0, voice_active=0, voice_restart=0, drop_count=0.
  - All age counters = 0; FSM goes to IDLE. Applies from any state; an event mid-scan is lost.
- Event normalisation: note-on with velocity 0 is treated as note-off.
- FSM states:
  - IDLE: evt_ready=1. Event accepted on evt_valid&&evt_ready; event latched; go to SCAN with index=0.
  - SCAN: evt_ready=0. Examines voice[index], one per cycle, index 0..NUM_VOICES-1. Records:
    - lowest-index active voice with matching note;
    - lowest-index inactive voice;
    - active voice with the highest age (ties: lowest index).
    - After index NUM_VOICES-1, go to COMMIT.
  - COMMIT: evt_ready=0. Applies the decision on the closing edge; go to IDLE.
- Latency: accept at edge E; voice outputs change at edge E+NUM_VOICES+1; next accept at earliest edge E+NUM_VOICES+2.
- Note-on decision priority: matching active voice (retrigger) > free voice > oldest voice (steal).
  - Target voice gets: note=evt_note, vol=evt_velocity, active=1, age=0, restart pulse high for the one cycle after COMMIT.
  - Every other active voice whose age is below the target's previous age (or all others, if target was free) increments age, saturating at NUM_VOICES-1.
- Note-off:
  - Matching active voice gets active=0, vol=0; voice_note is held; no restart pulse.
  - No match: no change.
  - Ages of remaining voices are unchanged.
- voice_restart is never high for more than one cycle and is high for at most one voice.
- Inactive voices always present vol=0.
- evt_valid may drop without acceptance; no state change results.

Optional Feature:
VOICE_STEAL_EN:
- Defined: when all voices are active and there is no note match, the oldest voice is stolen as above; drop_count stays 0.
- Undefined: the note-on is discarded, no voice changes, and drop_count increments, saturating at 255.
- Timing is identical in both builds.

Test Plan (NUM_VOICES=4, VOICE_STEAL_EN defined unless stated):
- Reset, then note-on 69 vel 100 → at edge E+5 voice0 note=69, vol=100, active=1; restart[0] pulses for one cycle; evt_ready low for cycles E+1..E+5.
- Note-ons 60, 62, 64, 65 → voices 0..3 in order; ages after last = 3, 2, 1, 0.
- Fifth note-on 67 with all voices busy → voice0 (age 3) stolen: note=67, age=0, restart[0] pulses; ages of voices 1..3 become 3, 2, 1.
- Note-on 62 vel 50 while 62 is playing on voice1 → voice1 retriggered with vol=50, restart[1] pulses; no other voice changes.
- Note-off 64, note-on 64 vel 0, and note-off 99 (unmatched) → voice2 inactive with vol=0; vel-0 event behaves as note-off; unmatched note-off changes nothing.
- VOICE_STEAL_EN undefined, all 4 voices busy, 3 new note-ons → no voice change, drop_count=3. Assert reset during SCAN → all outputs at reset values next cycle.
